// File: rtl/operand_seq.sv
// Operand sequencer: steps one latched instruction's operands through IP write, reads,
// pointer dereferences, ALU and write-back phases under a per-phase ack handshake.
module operand_seq #(
   parameter int unsigned NOPS  = 4,
   parameter int unsigned REGW  = 4,
   parameter int unsigned SLOTW = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [NOPS*(REGW+3)-1:0]   command,
   input  logic                       ack,
   input  logic                       cond_zero,
   output logic [3:0]                 phase,
   output logic [SLOTW-1:0]           slot,
   output logic                       busy,
   output logic                       done,
   output logic                       skipped
);

   localparam int NumOps   = NOPS;
   localparam int SlotBits = REGW + 3;
   localparam int CmdW     = NumOps * SlotBits;
   localparam logic [REGW-1:0] IpReg = '1;

   typedef enum logic [3:0] {
      Idle   = 4'd0,
      Pre    = 4'd1,
      WrIp   = 4'd2,
      Rd     = 4'd3,
      RdP    = 4'd4,
      Alu    = 4'd5,
      WbPrep = 4'd6,
      Wb     = 4'd7,
      Finish = 4'd8
   } phaseT;

   phaseT            phaseQ, phaseD;
   logic [SLOTW-1:0] slotQ, slotD;
   logic [CmdW-1:0]  cmdQ;
   logic             skipD;
   logic             ipHit;
   int               curPos;
   logic [SLOTW:0]   firstRd, afterRd, firstWr, afterWr;

   function automatic logic [REGW-1:0] regOf(input logic [CmdW-1:0] c, input int k);
      return c[k*SlotBits +: REGW];
   endfunction

   function automatic logic ptrOf(input logic [CmdW-1:0] c, input int k);
      return c[k*SlotBits + REGW];
   endfunction

   function automatic logic [1:0] flagsOf(input logic [CmdW-1:0] c, input int k);
      return c[k*SlotBits + REGW + 1 +: 2];
   endfunction

   // Lowest used non-dst slot at or above 'from'; {valid, index}.
   function automatic logic [SLOTW:0] nextRead(input logic [CmdW-1:0] c, input int from);
      logic [SLOTW:0] r;
      r = '0;
      for (int k = NumOps - 2; k >= 0; k--) begin
         if (k >= from && flagsOf(c, k) != 2'b11) r = {1'b1, SLOTW'(k)};
      end
      return r;
   endfunction

   // Write order position p: 0 is dst, p>0 is slot p-1.
   function automatic int posSlot(input int p);
      return (p == 0) ? NumOps - 1 : p - 1;
   endfunction

   function automatic logic isWr(input logic [CmdW-1:0] c, input int p);
      logic [1:0] f;
      f = flagsOf(c, posSlot(p));
      if (p == 0) return f != 2'b11;
      return f == 2'b01 || f == 2'b10;
   endfunction

   // A write survives only if no later write targets the same register.
   function automatic logic wrEff(input logic [CmdW-1:0] c, input int p);
      logic e;
      e = isWr(c, p);
      for (int q = 0; q < NumOps; q++) begin
         if (q > p && isWr(c, q) && regOf(c, posSlot(q)) == regOf(c, posSlot(p))) e = 1'b0;
      end
      return e;
   endfunction

   function automatic logic [SLOTW:0] nextWrite(input logic [CmdW-1:0] c, input int from);
      logic [SLOTW:0] r;
      r = '0;
      for (int q = NumOps - 1; q >= 0; q--) begin
         if (q >= from && wrEff(c, q)) r = {1'b1, SLOTW'(posSlot(q))};
      end
      return r;
   endfunction

   always_comb begin
      ipHit = 1'b0;
      for (int p = 0; p < NumOps; p++) begin
         if (isWr(cmdQ, p) && regOf(cmdQ, posSlot(p)) == IpReg) ipHit = 1'b1;
      end
      curPos  = (int'(slotQ) == NumOps - 1) ? 0 : int'(slotQ) + 1;
      firstRd = nextRead(cmdQ, 0);
      afterRd = nextRead(cmdQ, int'(slotQ) + 1);
      firstWr = nextWrite(cmdQ, 0);
      afterWr = nextWrite(cmdQ, curPos + 1);
   end

   always_comb begin
      phaseD = phaseQ;
      slotD  = slotQ;
      skipD  = 1'b0;
      unique case (phaseQ)
         Idle: begin
            if (start) phaseD = Pre;
         end
         Pre: begin
            if (ack) begin
               if (!ipHit) begin
                  phaseD = WrIp;
               end else if (firstRd[SLOTW]) begin
                  phaseD = Rd;
                  slotD  = firstRd[SLOTW-1:0];
               end else begin
                  phaseD = Alu;
               end
            end
         end
         WrIp: begin
            if (ack) begin
               if (firstRd[SLOTW]) begin
                  phaseD = Rd;
                  slotD  = firstRd[SLOTW-1:0];
               end else begin
                  phaseD = Alu;
               end
            end
         end
         Rd: begin
            if (ack) begin
               if (slotQ == '0 && !ptrOf(cmdQ, 0) && cond_zero) begin
                  phaseD = Finish;
                  skipD  = 1'b1;
               end else if (ptrOf(cmdQ, int'(slotQ))) begin
                  phaseD = RdP;
               end else if (afterRd[SLOTW]) begin
                  slotD  = afterRd[SLOTW-1:0];
               end else begin
                  phaseD = Alu;
               end
            end
         end
         RdP: begin
            if (ack) begin
               if (slotQ == '0 && cond_zero) begin
                  phaseD = Finish;
                  skipD  = 1'b1;
               end else if (afterRd[SLOTW]) begin
                  phaseD = Rd;
                  slotD  = afterRd[SLOTW-1:0];
               end else begin
                  phaseD = Alu;
               end
            end
         end
         Alu: begin
            if (ack) phaseD = WbPrep;
         end
         WbPrep: begin
            if (ack) begin
               if (firstWr[SLOTW]) begin
                  phaseD = Wb;
                  slotD  = firstWr[SLOTW-1:0];
               end else begin
                  phaseD = Finish;
               end
            end
         end
         Wb: begin
            if (ack) begin
               if (afterWr[SLOTW]) begin
                  slotD  = afterWr[SLOTW-1:0];
               end else begin
                  phaseD = Finish;
               end
            end
         end
         Finish: begin
            phaseD = Idle;
         end
         default: begin
            phaseD = Idle;
         end
      endcase
      if (phaseD != Rd && phaseD != RdP && phaseD != Wb) slotD = '0;
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         phaseQ  <= Idle;
         slotQ   <= '0;
         cmdQ    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         skipped <= 1'b0;
      end else begin
         phaseQ  <= phaseD;
         slotQ   <= slotD;
         if (phaseQ == Idle && start) cmdQ <= command;
         busy    <= phaseD != Idle;
         done    <= phaseD == Finish;
         skipped <= skipD;
      end
   end

   assign phase = phaseQ;
   assign slot  = slotQ;

endmodule

// File: doc/operand_seq.md
OPERAND_SEQ -- requirements
Module: operand_seq

Interface
REQ-001 SHALL have parameter NOPS, default 4, number of operand slots: slot 0 = cond, slots 1..NOPS-2 = sources, slot NOPS-1 = dst; legal range 3..8.
REQ-002 SHALL have parameter REGW, default 4, register-number width; the IP register is 2^REGW-1.
REQ-003 SHALL have parameter SLOTW, default 3, width of the slot output.
REQ-004 SHALL have port clk, input, 1, the only clock; all state updates on its falling edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, command valid; sampled only in IDLE.
REQ-007 SHALL have port command, input, NOPS*(REGW+3), packed slots; slot k = bits [k*(REGW+3) +: REGW+3] = {flags[1:0], isptr, regnum[REGW-1:0]}.
REQ-008 SHALL have port ack, input, 1, current phase complete; advances the sequencer.
REQ-009 SHALL have port cond_zero, input, 1, fetched cond value equals 0; sampled with ack in RD/RD_P of slot 0.
REQ-010 SHALL have port phase, output, 4, current phase code.
REQ-011 SHALL have port slot, output, SLOTW, slot index for RD/RD_P/WB; 0 otherwise.
REQ-012 SHALL have port busy, output, 1, high whenever phase != IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse in FINISH.
REQ-014 SHALL have port skipped, output, 1, high in FINISH when the cond test failed.

Function
REQ-015 SHALL encode phases as IDLE=0, PRE=1, WR_IP=2, RD=3, RD_P=4, ALU=5, WB_PREP=6, WB=7, FINISH=8.
REQ-016 SHALL latch command in IDLE when start=1 and go to PRE; start in any other phase is ignored.
REQ-017 SHALL leave every phase except IDLE and FINISH only on an edge with ack=1; with ack=0 the phase/slot SHALL hold.
REQ-018 SHALL treat a slot as unused when flags=2'b11, and as write-back when flags is 01 or 10 (post-modify); dst is written when flags != 11.
REQ-019 SHALL, in PRE, go to WR_IP unless the written dst or any write-back slot has regnum = IP register, in which case it goes straight to the first read.
REQ-020 SHALL read used slots 0..NOPS-2 in ascending order in RD; a slot with isptr=1 SHALL get RD_P with the same slot index after its RD; dst is never read.
REQ-021 SHALL go to ALU after the last read, or directly after PRE/WR_IP if no slot is read.
REQ-022 SHALL, on ack of slot 0 in RD with isptr=0 and cond_zero=1, or in RD_P with cond_zero=1, go to FINISH with skipped=1 and perform no write-back.
REQ-023 SHALL go ALU -> WB_PREP -> first write, or FINISH if none.
REQ-024 SHALL issue writes in order dst, then write-back slots 0..NOPS-2 ascending, one WB phase each.
REQ-025 SHALL suppress a write whose regnum equals the regnum of any later write in that order (last writer wins); suppressed writes take no cycles.
REQ-026 SHALL stay in FINISH exactly one cycle (done=1), then return to IDLE regardless of ack.
REQ-027 SHALL compute all next-slot selections combinationally from the latched command; no extra bubble cycles between phases.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, from any phase, go to IDLE with phase=0, slot=0, busy=0, done=0, skipped=0 and the latched command cleared; rst has priority over start and ack.

Verification
REQ-029 SHALL pass: NOPS=4, all slots flags=11 except dst reg 3 flags=00, ack held 1 -> phases PRE, WR_IP, ALU, WB_PREP, WB(slot 3), FINISH; done pulses once.
REQ-030 SHALL pass: cond slot reg 2 isptr=0 flags=00, cond_zero=1 on its RD ack -> next phase FINISH, skipped=1, no WB phase.
REQ-031 SHALL pass: src slot 1 isptr=1, cond unused, ack=1 -> RD(1), RD_P(1), ALU; ack=0 for 3 cycles mid RD_P holds phase=4, slot=1.
REQ-032 SHALL pass: dst reg 5, slot 1 reg 5 flags=01, slot 2 reg 6 flags=10 -> dst write suppressed; WB(1), WB(2), FINISH.
REQ-033 SHALL pass: dst reg 15 (IP) -> PRE goes directly to the first RD, WR_IP skipped.
REQ-034 SHALL pass: rst=1 during WB -> next edge phase=0, busy=0; start one cycle later begins a new sequence normally.
